// File: rtl/alu_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one external ALU between two requesters.  A round-robin arbiter
// accepts one operation at a time.  The accepted operands and opcode are held
// on the ALU inputs.  After ALU_LAT edges the ALU result is captured and then
// returned to the requester that issued the operation.  Only one operation is
// in flight at any time.
//
// Ports
//   clk                      sole clock, rising edge
//   rst                      asynchronous, active-high reset
//   req0_valid / req1_valid  requester has an operation pending
//   req0_ready / req1_ready  operation accepted this cycle (combinational)
//   reqN_a, reqN_b [7:0]     operands of requester N
//   reqN_oper [3:0]          opcode of requester N, forwarded unmodified
//   resp0_valid/resp1_valid  result available for requester N
//   resp0_ready/resp1_ready  requester N consumes the result
//   respN_data [15:0]        result {msb,lsb}; zero when not valid
//   alu_a, alu_b [7:0]       operands driven to the shared ALU
//   alu_oper [3:0]           opcode driven to the shared ALU
//   alu_msb, alu_lsb [7:0]   ALU result halves
//   busy                     high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [7:0]  req0_a,
    input  logic [7:0]  req0_b,
    input  logic [3:0]  req0_oper,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [7:0]  req1_a,
    input  logic [7:0]  req1_b,
    input  logic [3:0]  req1_oper,

    output logic        resp0_valid,
    input  logic        resp0_ready,
    output logic [15:0] resp0_data,

    output logic        resp1_valid,
    input  logic        resp1_ready,
    output logic [15:0] resp1_data,

    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [3:0]  alu_oper,
    input  logic [7:0]  alu_msb,
    input  logic [7:0]  alu_lsb,

    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Counter reload value; ALU_LAT is limited to 1..7 so three bits suffice.
    localparam logic [2:0] LAT_LOAD = 3'(ALU_LAT);

    state_t      state_r;
    logic [2:0]  cnt_r;
    logic [7:0]  a_r;
    logic [7:0]  b_r;
    logic [3:0]  oper_r;
    logic        gnt_r;        // owner of the in-flight operation
    logic        last_r;       // requester granted most recently
    logic        resp0_valid_r;
    logic        resp1_valid_r;
    logic [15:0] resp0_data_r;
    logic [15:0] resp1_data_r;

    logic        any_s;
    logic        grant_s;
    logic        accept_s;
    logic        hs_s;
    logic [7:0]  sel_a_s;
    logic [7:0]  sel_b_s;
    logic [3:0]  sel_oper_s;

    // Round-robin choice: on contention the requester that did not win last
    // time is picked; a lone requester always wins.
    function automatic logic pick_grant(input logic v0, input logic v1, input logic last);
        logic g;
        if (v0 && v1) begin
            g = ~last;
        end else if (v1) begin
            g = 1'b1;
        end else begin
            g = 1'b0;
        end
        return g;
    endfunction

    // Arbitration and accept qualification.
    always_comb begin
        any_s    = req0_valid | req1_valid;
        grant_s  = pick_grant(req0_valid, req1_valid, last_r);
        accept_s = (state_r == IDLE) && any_s;
    end

    // Ready is combinational so a request can be taken in the cycle it is seen.
    always_comb begin
        if (accept_s) begin
            req0_ready = ~grant_s;
            req1_ready = grant_s;
        end else begin
            req0_ready = 1'b0;
            req1_ready = 1'b0;
        end
    end

    // Operand mux feeding the latch registers on accept.
    always_comb begin
        if (grant_s) begin
            sel_a_s    = req1_a;
            sel_b_s    = req1_b;
            sel_oper_s = req1_oper;
        end else begin
            sel_a_s    = req0_a;
            sel_b_s    = req0_b;
            sel_oper_s = req0_oper;
        end
    end

    // Response handshake; ready from the non-owning requester is ignored.
    always_comb begin
        if (state_r == RESP) begin
            if (gnt_r) begin
                hs_s = resp1_valid_r & resp1_ready;
            end else begin
                hs_s = resp0_valid_r & resp0_ready;
            end
        end else begin
            hs_s = 1'b0;
        end
    end

    // Main FSM: accept, wait ALU_LAT edges, capture, hold result until consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            cnt_r         <= 3'd0;
            a_r           <= 8'h00;
            b_r           <= 8'h00;
            oper_r        <= 4'h0;
            gnt_r         <= 1'b0;
            last_r        <= 1'b1;
            resp0_valid_r <= 1'b0;
            resp1_valid_r <= 1'b0;
            resp0_data_r  <= 16'h0000;
            resp1_data_r  <= 16'h0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        a_r     <= sel_a_s;
                        b_r     <= sel_b_s;
                        oper_r  <= sel_oper_s;
                        gnt_r   <= grant_s;
                        last_r  <= grant_s;
                        cnt_r   <= LAT_LOAD;
                        state_r <= EXEC;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                EXEC: begin
                    if (cnt_r != 3'd0) begin
                        cnt_r <= cnt_r - 3'd1;
                    end else begin
                        // ALU output is valid now: route it to the owner only.
                        if (gnt_r) begin
                            resp1_valid_r <= 1'b1;
                            resp1_data_r  <= {alu_msb, alu_lsb};
                            resp0_valid_r <= 1'b0;
                            resp0_data_r  <= 16'h0000;
                        end else begin
                            resp0_valid_r <= 1'b1;
                            resp0_data_r  <= {alu_msb, alu_lsb};
                            resp1_valid_r <= 1'b0;
                            resp1_data_r  <= 16'h0000;
                        end
                        state_r <= RESP;
                    end
                end
                RESP: begin
                    if (hs_s) begin
                        resp0_valid_r <= 1'b0;
                        resp1_valid_r <= 1'b0;
                        resp0_data_r  <= 16'h0000;
                        resp1_data_r  <= 16'h0000;
                        state_r       <= IDLE;
                    end else begin
                        state_r <= RESP;
                    end
                end
                default: begin
                    state_r       <= IDLE;
                    cnt_r         <= 3'd0;
                    resp0_valid_r <= 1'b0;
                    resp1_valid_r <= 1'b0;
                    resp0_data_r  <= 16'h0000;
                    resp1_data_r  <= 16'h0000;
                end
            endcase
        end
    end

    // Outputs come straight from registers.
    assign alu_a       = a_r;
    assign alu_b       = b_r;
    assign alu_oper    = oper_r;
    assign resp0_valid = resp0_valid_r;
    assign resp1_valid = resp1_valid_r;
    assign resp0_data  = resp0_data_r;
    assign resp1_data  = resp1_data_r;
    assign busy        = (state_r != IDLE);

endmodule
